// File: rtl/acc_in_packer.sv
// Packs serial signed 8-bit samples into 4-lane vectors X1..X4, padding short frames ended by last.
// Latency: vector valid the cycle after its final sample is accepted; 1 vector per 4 cycles sustained.
// Backpressure: ready=1 while filling; while a vector is pending ready follows ready_out combinationally.
module acc_in_packer #(
    parameter logic signed [7:0] PAD_VALUE = 8'sd0,
    parameter int                CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic signed [7:0]       din,
    input  logic                    valid,
    input  logic                    last,
    output logic                    ready,
    output logic signed [7:0]       X1,
    output logic signed [7:0]       X2,
    output logic signed [7:0]       X3,
    output logic signed [7:0]       X4,
    output logic                    valid_out,
    input  logic                    ready_out,
    output logic                    padded,
    output logic [CNT_W-1:0]        vec_cnt
);

    typedef enum logic {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [1:0]             r_lane;
    logic [1:0]             w_lane_nxt;
    logic signed [7:0]      r_x [4];
    logic signed [7:0]      w_x_nxt [4];
    logic                   r_padded;
    logic                   w_padded_nxt;
    logic [CNT_W-1:0]       r_vec_cnt;
    logic                   w_accept;
    logic                   w_handoff;

    // While a vector is pending a new sample can only enter on the handoff cycle,
    // so ready mirrors ready_out there; reset forces it low.
    assign ready     = arst & ((r_state == S_FILL) | ready_out);
    assign valid_out = (r_state == S_FULL);
    assign w_accept  = valid & ready;
    assign w_handoff = valid_out & ready_out;

    assign X1      = r_x[0];
    assign X2      = r_x[1];
    assign X3      = r_x[2];
    assign X4      = r_x[3];
    assign padded  = r_padded;
    assign vec_cnt = r_vec_cnt;

    // Next-state and lane/data update: fill lanes in order, close on lane 3 or last.
    always_comb begin
        w_state_nxt  = r_state;
        w_lane_nxt   = r_lane;
        w_padded_nxt = r_padded;
        for (int i = 0; i < 4; i++) begin
            w_x_nxt[i] = r_x[i];
        end
        case (r_state)
            S_FILL: begin
                if (w_accept) begin
                    for (int i = 0; i < 4; i++) begin
                        if (2'(i) == r_lane) begin
                            w_x_nxt[i] = din;
                        end else if ((2'(i) > r_lane) && last) begin
                            w_x_nxt[i] = PAD_VALUE;
                        end
                    end
                    if ((r_lane == 2'd3) || last) begin
                        w_state_nxt  = S_FULL;
                        w_lane_nxt   = 2'd0;
                        w_padded_nxt = last && (r_lane != 2'd3);
                    end else begin
                        w_lane_nxt = r_lane + 2'd1;
                    end
                end
            end
            S_FULL: begin
                if (w_handoff) begin
                    if (w_accept) begin
                        w_x_nxt[0] = din;
                        if (last) begin
                            // A one-sample frame closes immediately into a new padded vector.
                            w_x_nxt[1]   = PAD_VALUE;
                            w_x_nxt[2]   = PAD_VALUE;
                            w_x_nxt[3]   = PAD_VALUE;
                            w_padded_nxt = 1'b1;
                            w_state_nxt  = S_FULL;
                            w_lane_nxt   = 2'd0;
                        end else begin
                            w_state_nxt = S_FILL;
                            w_lane_nxt  = 2'd1;
                        end
                    end else begin
                        w_state_nxt = S_FILL;
                        w_lane_nxt  = 2'd0;
                    end
                end
            end
            default: begin
                w_state_nxt = S_FILL;
                w_lane_nxt  = 2'd0;
            end
        endcase
    end

    // State register; reset discards any partial or pending vector.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Lane counter, vector lanes and padded flag.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_lane   <= 2'd0;
            r_padded <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_x[i] <= 8'sd0;
            end
        end else begin
            r_lane   <= w_lane_nxt;
            r_padded <= w_padded_nxt;
            for (int i = 0; i < 4; i++) begin
                r_x[i] <= w_x_nxt[i];
            end
        end
    end

    // Count of vectors handed to the accelerator, free-running with wrap.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_vec_cnt <= '0;
        end else if (w_handoff) begin
            r_vec_cnt <= r_vec_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_acc_in_packer.sv
module tb_acc_in_packer;

    logic              clk = 1'b0;
    logic              arst = 1'b0;
    logic signed [7:0] din = 8'sd0;
    logic              valid = 1'b0;
    logic              last = 1'b0;
    logic              ready_out = 1'b0;

    logic              ready;
    logic signed [7:0] X1, X2, X3, X4;
    logic              valid_out;
    logic              padded;
    logic [15:0]       vec_cnt;

    logic              ready2;
    logic signed [7:0] Y1, Y2, Y3, Y4;
    logic              valid_out2;
    logic              padded2;
    logic [1:0]        vec_cnt2;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a queue of samples in the current frame and one pending vector.
    logic signed [7:0] m_part [$];
    logic signed [7:0] m_vec [4];
    bit                m_full;
    bit                m_pad;
    int                m_cnt;

    acc_in_packer #(.PAD_VALUE(8'sd0), .CNT_W(16)) u_dut (
        .clk(clk), .arst(arst), .din(din), .valid(valid), .last(last), .ready(ready),
        .X1(X1), .X2(X2), .X3(X3), .X4(X4), .valid_out(valid_out), .ready_out(ready_out),
        .padded(padded), .vec_cnt(vec_cnt)
    );

    acc_in_packer #(.PAD_VALUE(8'sd0), .CNT_W(2)) u_dut_w2 (
        .clk(clk), .arst(arst), .din(din), .valid(valid), .last(last), .ready(ready2),
        .X1(Y1), .X2(Y2), .X3(Y3), .X4(Y4), .valid_out(valid_out2), .ready_out(ready_out),
        .padded(padded2), .vec_cnt(vec_cnt2)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_part.delete();
        m_full = 1'b0;
        m_pad  = 1'b0;
        m_cnt  = 0;
        for (int i = 0; i < 4; i++) m_vec[i] = 8'sd0;
    endtask

    // Apply inputs shortly after a rising edge, let combinational ready settle.
    task automatic drive(input bit v, input bit l, input logic signed [7:0] d, input bit ro);
        valid = v; last = l; din = d; ready_out = ro;
        #1;
    endtask

    // Advance one clock and update the model from the handshake rules.
    task automatic tick();
        bit rdy_e, acc, hand;
        int n;
        rdy_e = m_full ? ready_out : 1'b1;
        acc   = valid && rdy_e;
        hand  = m_full && ready_out;
        @(posedge clk);
        if (hand) begin
            m_cnt++;
            m_full = 1'b0;
        end
        if (acc) begin
            m_part.push_back(din);
            if (m_part.size() == 4 || last) begin
                n = m_part.size();
                for (int i = 0; i < 4; i++) m_vec[i] = (i < n) ? m_part[i] : 8'sd0;
                m_pad  = (n < 4);
                m_full = 1'b1;
                m_part.delete();
            end
        end
        #1;
    endtask

    task automatic send(input logic signed [7:0] d, input bit l, input bit ro);
        drive(1'b1, l, d, ro);
        tick();
    endtask

    task automatic do_reset();
        valid = 1'b0; last = 1'b0;
        arst = 1'b0;
        #3;
        model_reset();
        arst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        ready_out = 1'b1;
        #2;
        n_checks++;
        if ({X1, X2, X3, X4} !== 32'h0) $display("FAIL reset_x got=%h exp=0", {X1, X2, X3, X4});
        else n_pass++;
        n_checks++;
        if ({valid_out, padded, ready} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {valid_out, padded, ready});
        else n_pass++;
        n_checks++;
        if (vec_cnt !== 16'd0) $display("FAIL reset_cnt got=%0d exp=0", vec_cnt);
        else n_pass++;
        #1;
        arst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        // Build state: one vector handed off, a padded vector pending.
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b0, 1'b1);
        drive(1'b0, 1'b0, 8'sd0, 1'b1);
        tick();
        send(8'sd5, 1'b0, 1'b0);
        send(8'sd6, 1'b1, 1'b0);
        n_checks++;
        if ({valid_out, padded, vec_cnt} !== {2'b11, 16'd1}) $display("FAIL pre_reset got=%b/%b/%0d exp=1/1/1", valid_out, padded, vec_cnt);
        else n_pass++;
        drive(1'b1, 1'b0, 8'sd77, 1'b1);
        arst = 1'b0;
        #1;
        n_checks++;
        if ({X1, X2, X3, X4} !== 32'h0) $display("FAIL midreset_x got=%h exp=0", {X1, X2, X3, X4});
        else n_pass++;
        n_checks++;
        if ({valid_out, padded, ready} !== 3'b000) $display("FAIL midreset_flags got=%b exp=000", {valid_out, padded, ready});
        else n_pass++;
        n_checks++;
        if (vec_cnt !== 16'd0) $display("FAIL midreset_cnt got=%0d exp=0", vec_cnt);
        else n_pass++;
        valid = 1'b0;
        #2;
        model_reset();
        arst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_stream();
        logic signed [7:0] b;
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 1'b0, 8'(i), 1'b1);
            n_checks++;
            if (ready !== 1'b1) $display("FAIL stream_ready i=%0d got=%b exp=1", i, ready);
            else n_pass++;
            tick();
            n_checks++;
            if (valid_out !== (i % 4 == 0)) $display("FAIL stream_vld i=%0d got=%b exp=%b", i, valid_out, (i % 4 == 0));
            else n_pass++;
            if (i % 4 == 0) begin
                b = 8'(i - 3);
                n_checks++;
                if ({X1, X2, X3, X4, padded} !== {b, b + 8'sd1, b + 8'sd2, b + 8'sd3, 1'b0})
                    $display("FAIL stream_vec i=%0d got=%0d,%0d,%0d,%0d p=%b exp=%0d..%0d p=0", i, X1, X2, X3, X4, padded, b, b + 8'sd3);
                else n_pass++;
            end
        end
        drive(1'b0, 1'b0, 8'sd0, 1'b1);
        tick();
        n_checks++;
        if ({valid_out, vec_cnt} !== {1'b0, 16'd2}) $display("FAIL stream_cnt got=%b/%0d exp=0/2", valid_out, vec_cnt);
        else n_pass++;
    endtask

    task automatic test_stall();
        do_reset();
        send(8'sd10, 1'b0, 1'b0);
        send(-8'sd20, 1'b0, 1'b0);
        send(8'sd30, 1'b0, 1'b0);
        send(-8'sd40, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 1'b0, 8'sd55, 1'b0);
            n_checks++;
            if (ready !== 1'b0) $display("FAIL stall_ready c=%0d got=%b exp=0", c, ready);
            else n_pass++;
            tick();
            n_checks++;
            if ({valid_out, X1, X2, X3, X4} !== {1'b1, 8'sd10, -8'sd20, 8'sd30, -8'sd40})
                $display("FAIL stall_hold c=%0d got=%b %0d,%0d,%0d,%0d exp=1 10,-20,30,-40", c, valid_out, X1, X2, X3, X4);
            else n_pass++;
        end
        n_checks++;
        if (vec_cnt !== 16'd0) $display("FAIL stall_cnt0 got=%0d exp=0", vec_cnt);
        else n_pass++;
        drive(1'b1, 1'b0, 8'sd55, 1'b1);
        n_checks++;
        if (ready !== 1'b1) $display("FAIL stall_release got=%b exp=1", ready);
        else n_pass++;
        tick();
        n_checks++;
        if ({valid_out, vec_cnt} !== {1'b0, 16'd1}) $display("FAIL stall_handoff got=%b/%0d exp=0/1", valid_out, vec_cnt);
        else n_pass++;
        send(8'sd56, 1'b0, 1'b1);
        send(8'sd57, 1'b0, 1'b1);
        send(8'sd58, 1'b0, 1'b1);
        n_checks++;
        if ({valid_out, X1, X2, X3, X4} !== {1'b1, 8'sd55, 8'sd56, 8'sd57, 8'sd58})
            $display("FAIL stall_next got=%b %0d,%0d,%0d,%0d exp=1 55,56,57,58", valid_out, X1, X2, X3, X4);
        else n_pass++;
    endtask

    task automatic test_pad();
        do_reset();
        send(-8'sd3, 1'b0, 1'b1);
        send(8'sd5, 1'b1, 1'b1);
        n_checks++;
        if ({valid_out, padded, X1, X2, X3, X4} !== {2'b11, -8'sd3, 8'sd5, 8'sd0, 8'sd0})
            $display("FAIL pad_vec got=%b/%b %0d,%0d,%0d,%0d exp=1/1 -3,5,0,0", valid_out, padded, X1, X2, X3, X4);
        else n_pass++;
        for (int i = 1; i <= 4; i++) send(8'(i), (i == 4), 1'b1);
        n_checks++;
        if ({valid_out, padded, X1, X2, X3, X4} !== {2'b10, 8'sd1, 8'sd2, 8'sd3, 8'sd4})
            $display("FAIL pad_full got=%b/%b %0d,%0d,%0d,%0d exp=1/0 1,2,3,4", valid_out, padded, X1, X2, X3, X4);
        else n_pass++;
    endtask

    task automatic test_reset_midfill();
        do_reset();
        send(8'sd1, 1'b0, 1'b1);
        send(8'sd2, 1'b0, 1'b1);
        do_reset();
        for (int i = 7; i <= 10; i++) send(8'(i), 1'b0, 1'b1);
        n_checks++;
        if ({valid_out, padded, X1, X2, X3, X4} !== {2'b10, 8'sd7, 8'sd8, 8'sd9, 8'sd10})
            $display("FAIL midfill_vec got=%b/%b %0d,%0d,%0d,%0d exp=1/0 7,8,9,10", valid_out, padded, X1, X2, X3, X4);
        else n_pass++;
        drive(1'b0, 1'b0, 8'sd0, 1'b1);
        tick();
        n_checks++;
        if (vec_cnt !== 16'd1) $display("FAIL midfill_cnt got=%0d exp=1", vec_cnt);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b0, 1'b1);
        drive(1'b1, 1'b1, 8'sd99, 1'b1);
        n_checks++;
        if (ready !== 1'b1) $display("FAIL b2b_ready got=%b exp=1", ready);
        else n_pass++;
        tick();
        n_checks++;
        if ({valid_out, padded, X1, X2, X3, X4, vec_cnt} !== {2'b11, 8'sd99, 8'sd0, 8'sd0, 8'sd0, 16'd1})
            $display("FAIL b2b_vec got=%b/%b %0d,%0d,%0d,%0d cnt=%0d exp=1/1 99,0,0,0 cnt=1", valid_out, padded, X1, X2, X3, X4, vec_cnt);
        else n_pass++;
        // Five vectors into the 2-bit counter instance.
        do_reset();
        for (int i = 0; i < 20; i++) send(8'(i), 1'b0, 1'b1);
        drive(1'b0, 1'b0, 8'sd0, 1'b1);
        tick();
        n_checks++;
        if (vec_cnt2 !== 2'd1) $display("FAIL wrap_cnt2 got=%0d exp=1", vec_cnt2);
        else n_pass++;
        n_checks++;
        if (vec_cnt !== 16'd5) $display("FAIL wrap_cnt16 got=%0d exp=5", vec_cnt);
        else n_pass++;
    endtask

    task automatic test_random();
        bit v, l, ro;
        logic signed [7:0] d;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            v  = ($urandom_range(0, 3) != 0);
            l  = ($urandom_range(0, 5) == 0);
            d  = 8'($urandom);
            ro = ($urandom_range(0, 2) != 0);
            drive(v, l, d, ro);
            n_checks++;
            if (ready !== (m_full ? ro : 1'b1)) $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, ready, (m_full ? ro : 1'b1));
            else n_pass++;
            tick();
            n_checks++;
            if (valid_out !== m_full) $display("FAIL rnd_vld c=%0d got=%b exp=%b", c, valid_out, m_full);
            else n_pass++;
            if (m_full) begin
                n_checks++;
                if ({X1, X2, X3, X4, padded} !== {m_vec[0], m_vec[1], m_vec[2], m_vec[3], m_pad})
                    $display("FAIL rnd_vec c=%0d got=%0d,%0d,%0d,%0d p=%b exp=%0d,%0d,%0d,%0d p=%b",
                             c, X1, X2, X3, X4, padded, m_vec[0], m_vec[1], m_vec[2], m_vec[3], m_pad);
                else n_pass++;
            end
            n_checks++;
            if ({vec_cnt, vec_cnt2} !== {16'(m_cnt), 2'(m_cnt)})
                $display("FAIL rnd_cnt c=%0d got=%0d/%0d exp=%0d/%0d", c, vec_cnt, vec_cnt2, 16'(m_cnt), 2'(m_cnt));
            else n_pass++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_stall();
        test_pad();
        test_reset_midfill();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
